// File: rtl/bus_pkg.sv
// Shared widths, responder state encoding and window-decode helper for the memory bus.
package bus_pkg;

    localparam int unsigned ADDR_WIDTH = 20;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_FETCH = 2'd1,
        RD_RESP  = 2'd2,
        WR_ACK   = 2'd3
    } resp_state_t;

    // Widened to 64 bits so start + size can never overflow the compare.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] start,
                                       input logic [63:0] size);
        return (addr >= start) && (addr < (start + size));
    endfunction

endpackage

// File: rtl/bus_sp_ram.sv
// Synchronous single-port RAM with registered read data; contents survive reset.
module bus_sp_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    d,
    output logic [DATA_WIDTH-1:0]    q
);

    logic [DATA_WIDTH-1:0] buffer [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                buffer[addr] <= d;
            end else begin
                q <= buffer[addr];
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-bus responder: window decode, access FSM, tristate read return and
// saturating access counters around an internal single-port RAM.
module bus_mem_responder #(
    parameter int unsigned             ADDR_WIDTH    = bus_pkg::ADDR_WIDTH,
    parameter int unsigned             DATA_WIDTH    = bus_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]   START_ADDRESS = '0,
    parameter int unsigned             SIZE          = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  bus_ready,
    output logic                  bus_error,
    output logic [15:0]           read_count,
    output logic [15:0]           write_count
);

    import bus_pkg::*;

    localparam int unsigned IDX_W = $clog2(SIZE);

    resp_state_t           state;
    logic                  rd_oe;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  hit_c;
    logic                  idle_c;
    logic                  ram_we_c;
    logic                  ram_re_c;
    logic [IDX_W-1:0]      idx_c;

    // Decode only matters in IDLE; other states ignore the bus entirely.
    assign hit_c    = in_window(64'(bus_addr), 64'(START_ADDRESS), 64'(SIZE));
    assign idx_c    = IDX_W'(bus_addr - START_ADDRESS);
    assign idle_c   = (state == IDLE);
    assign ram_we_c = idle_c && hit_c && mem_write && !mem_read;
    assign ram_re_c = idle_c && hit_c && mem_read && !mem_write;

    bus_sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SIZE)
    ) u_ram (
        .clk  (clk),
        .en   (ram_we_c || ram_re_c),
        .we   (ram_we_c),
        .addr (idx_c),
        .d    (bus_data),
        .q    (ram_q)
    );

    // Output enable is a register, so the bus is never driven from a bus input path.
    assign bus_data = rd_oe ? rd_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus_ready   <= 1'b0;
            bus_error   <= 1'b0;
            rd_oe       <= 1'b0;
            rd_q        <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            bus_ready <= 1'b0;
            bus_error <= 1'b0;
            rd_oe     <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit_c && mem_read && mem_write) begin
                        bus_error <= 1'b1;
                    end else if (ram_re_c) begin
                        state <= RD_FETCH;
                    end else if (ram_we_c) begin
                        state     <= WR_ACK;
                        bus_ready <= 1'b1;
                    end
                end
                RD_FETCH: begin
                    rd_q      <= ram_q;
                    state     <= RD_RESP;
                    bus_ready <= 1'b1;
                    rd_oe     <= 1'b1;
                end
                RD_RESP: begin
                    state <= IDLE;
                    if (read_count != 16'hFFFF) begin
                        read_count <= read_count + 16'd1;
                    end
                end
                WR_ACK: begin
                    state <= IDLE;
                    if (write_count != 16'hFFFF) begin
                        write_count <= write_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: two instances on separate buses with different windows.
`timescale 1ns/1ps
module tb_bus_mem_responder;
    import bus_pkg::*;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned SZ = 1024;
    localparam logic [DW-1:0] FLOAT = 16'hFFFF;
    localparam logic [AW-1:0] BASE1 = 20'h00400;

    typedef struct packed {
        logic          dut;
        logic          is_rd;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0][AW-1:0] addr;
    logic [1:0]         rd;
    logic [1:0]         wr;
    logic [1:0]         drv_en;
    logic [1:0][DW-1:0] drv_val;
    wire  [1:0]         ready;
    wire  [1:0]         err;
    wire  [1:0][15:0]   rcnt;
    wire  [1:0][15:0]   wcnt;
    tri1  [DW-1:0]      bus0;
    tri1  [DW-1:0]      bus1;

    exp_t          exp_q[$];
    logic [DW-1:0] model [2][SZ];
    int unsigned   m_rc [2];
    int unsigned   m_wc [2];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;

    assign bus0 = drv_en[0] ? drv_val[0] : {DW{1'bz}};
    assign bus1 = drv_en[1] ? drv_val[1] : {DW{1'bz}};

    bus_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDRESS(20'h00000), .SIZE(SZ)) dut0 (
        .clk(clk), .reset(reset), .bus_addr(addr[0]), .bus_data(bus0),
        .mem_read(rd[0]), .mem_write(wr[0]), .bus_ready(ready[0]), .bus_error(err[0]),
        .read_count(rcnt[0]), .write_count(wcnt[0])
    );

    bus_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDRESS(BASE1), .SIZE(SZ)) dut1 (
        .clk(clk), .reset(reset), .bus_addr(addr[1]), .bus_data(bus1),
        .mem_read(rd[1]), .mem_write(wr[1]), .bus_ready(ready[1]), .bus_error(err[1]),
        .read_count(rcnt[1]), .write_count(wcnt[1])
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bus_val(input int d);
        return (d == 0) ? bus0 : bus1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_counts(input int d);
        check("read_count", 32'(rcnt[d]), 32'(m_rc[d]));
        check("write_count", 32'(wcnt[d]), 32'(m_wc[d]));
    endtask

    // Scoreboard monitor: every ready cycle must match the oldest expected response.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (ready[d]) begin
                    if (exp_q.size() == 0 || exp_q[0].dut != 1'(d)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready dut=%0d actual=1 required=0", d);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.is_rd) check("rd_data", 32'(bus_val(d)), 32'(e.data));
                        check("ack_no_error", 32'(err[d]), 32'd0);
                    end
                end else if (!drv_en[d]) begin
                    check("bus_float", 32'(bus_val(d)), 32'(FLOAT));
                end
            end
        end
    end

    task automatic do_access(input int d, input logic [AW-1:0] a, input bit is_wr, input logic [DW-1:0] data);
        logic [AW-1:0] base;
        bit            hit;
        int            n;
        int unsigned   idx;
        base = (d == 0) ? 20'h00000 : BASE1;
        hit  = (a >= base) && ({1'b0, a} < ({1'b0, base} + 21'(SZ)));
        idx  = hit ? 32'(a - base) : 0;
        @(negedge clk);
        addr[d] = a;
        if (is_wr) begin
            wr[d] = 1'b1; drv_en[d] = 1'b1; drv_val[d] = data;
        end else begin
            rd[d] = 1'b1;
        end
        if (hit) begin
            exp_q.push_back('{dut: 1'(d), is_rd: !is_wr, data: is_wr ? data : model[d][idx]});
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (!ready[d] && n < 8);
            check(is_wr ? "wr_latency" : "rd_latency", 32'(n), is_wr ? 32'd1 : 32'd2);
            rd[d] = 1'b0; wr[d] = 1'b0; drv_en[d] = 1'b0;
            @(posedge clk); #1;
            if (is_wr) begin
                model[d][idx] = data;
                if (m_wc[d] < 32'hFFFF) m_wc[d]++;
            end else if (m_rc[d] < 32'hFFFF) begin
                m_rc[d]++;
            end
            check("ready_done", 32'(ready[d]), 32'd0);
        end else begin
            repeat (4) begin
                @(posedge clk); #1;
                check("miss_ready", 32'(ready[d]), 32'd0);
            end
            rd[d] = 1'b0; wr[d] = 1'b0; drv_en[d] = 1'b0;
            @(posedge clk); #1;
        end
        check_counts(d);
    endtask

    task automatic do_both(input int d, input logic [AW-1:0] a);
        @(negedge clk);
        addr[d] = a; rd[d] = 1'b1; wr[d] = 1'b1; drv_en[d] = 1'b1; drv_val[d] = 16'h5A5A;
        @(posedge clk); #1;
        check("err_pulse", 32'(err[d]), 32'd1);
        check("err_ready", 32'(ready[d]), 32'd0);
        rd[d] = 1'b0; wr[d] = 1'b0; drv_en[d] = 1'b0;
        @(posedge clk); #1;
        check("err_clear", 32'(err[d]), 32'd0);
        check("err_ready2", 32'(ready[d]), 32'd0);
        check_counts(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        int            d;
        addr = '0; rd = '0; wr = '0; drv_en = '0; drv_val = '0;
        for (int i = 0; i < 2; i++) begin
            m_rc[i] = 0;
            m_wc[i] = 0;
        end
        for (int i = 0; i < int'(SZ); i++) begin
            model[0][i] = DW'(i * 37 + 256);
            model[1][i] = DW'(i * 53 + 7);
            dut0.u_ram.buffer[i] = model[0][i];
            dut1.u_ram.buffer[i] = model[1][i];
        end
        model[0][5] = 16'hBEEF;
        dut0.u_ram.buffer[5] = 16'hBEEF;

        #1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_error", 32'(err), 32'd0);
        check("rst_bus0", 32'(bus0), 32'(FLOAT));
        check_counts(0);
        @(negedge clk);
        reset = 1'b1;

        // Preloaded read, then write/readback at the window top.
        do_access(0, 20'h00005, 1'b0, '0);
        check("bus_released", 32'(bus0), 32'(FLOAT));
        do_access(0, 20'h003FF, 1'b1, 16'h1234);
        do_access(0, 20'h003FF, 1'b0, '0);

        // Offset window: both neighbours miss, first word hits.
        do_access(1, 20'h003FF, 1'b0, '0);
        do_access(1, 20'h00800, 1'b0, '0);
        do_access(1, 20'h00400, 1'b0, '0);

        // Conflicting strobes, then confirm RAM was untouched.
        do_both(0, 20'h00010);
        do_access(0, 20'h00010, 1'b0, '0);

        // Reset while a read is in RD_FETCH.
        @(negedge clk);
        addr[0] = 20'h003FF; rd[0] = 1'b1;
        @(posedge clk); #1;
        check("in_fetch", 32'(dut0.state), 32'(RD_FETCH));
        reset = 1'b0;
        #1;
        rd[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_rc[i] = 0;
            m_wc[i] = 0;
        end
        check("rst_mid_ready", 32'(ready[0]), 32'd0);
        check("rst_mid_bus", 32'(bus0), 32'(FLOAT));
        check_counts(0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_state", 32'(dut0.state), 32'(IDLE));
        do_access(0, 20'h003FF, 1'b0, '0);

        // Write counter saturation.
        @(negedge clk);
        dut0.write_count = 16'hFFFE;
        m_wc[0] = 32'hFFFE;
        for (int i = 0; i < 3; i++) do_access(0, AW'(20 + i), 1'b1, DW'(16'h0A00 + i));
        check("wc_saturated", 32'(wcnt[0]), 32'h0000FFFF);

        // Randomised mix of reads, writes and misses on both instances.
        for (int k = 0; k < 120; k++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                if (d == 0) a = AW'(32'h400 + $urandom_range(0, 32'hFFBFF));
                else if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 32'h3FF));
                else a = AW'(32'h800 + $urandom_range(0, 32'hFF7FF));
            end else begin
                a = ((d == 0) ? 20'h00000 : BASE1) + AW'($urandom_range(0, SZ - 1));
            end
            do_access(d, a, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 32'hFFFE)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
